// File: rtl/wallace_product_accumulator_if.sv
// Handshake bundle between the Wallace product unit and the product accumulator.
// Ports: start, in_valid/in_ready/product (product stream), out_valid/out_ready/acc/ovf (result), busy.
// master = producer/consumer side (testbench or datapath), slave = accumulator.
interface wallace_product_accumulator_if #(
    parameter int ACC_WIDTH = 19
);
    logic                 start;
    logic                 in_valid;
    logic                 in_ready;
    logic [15:0]          product;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] acc;
    logic                 ovf;
    logic                 busy;

    modport master (
        output start, in_valid, product, out_ready,
        input  in_ready, out_valid, acc, ovf, busy
    );

    modport slave (
        input  start, in_valid, product, out_ready,
        output in_ready, out_valid, acc, ovf, busy
    );
endinterface

// File: rtl/wallace_product_accumulator.sv
// Sums N_TERMS consecutive 16-bit unsigned products into one dot-product result.
// Latency: result valid the cycle after the N_TERMS-th accepted product (N_TERMS+1 from start minimum).
// Backpressure: in_ready only in ACCUM; result held in DONE until out_ready.
// Ports: i_clk, i_rst (sync, active-high), io_bus (slave modport of wallace_product_accumulator_if).
module wallace_product_accumulator #(
    parameter int N_TERMS   = 8,
    parameter int ACC_WIDTH = 19
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    wallace_product_accumulator_if.slave  io_bus
);
    localparam int CNT_W = $clog2(N_TERMS + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;
    logic [ACC_WIDTH-1:0] r_acc;
    logic                 r_ovf;
    logic [CNT_W-1:0]     r_count;

    logic                 w_xfer;
    logic                 w_last;
    logic [ACC_WIDTH:0]   w_sum;

    // Product is taken straight from the bus at the edge; the extra top bit
    // of the sum is the carry out of the accumulator MSB.
    assign w_xfer = (r_state == S_ACCUM) && io_bus.in_valid;
    assign w_last = (r_count == CNT_W'(N_TERMS - 1));
    assign w_sum  = {1'b0, r_acc} + {{(ACC_WIDTH - 15){1'b0}}, io_bus.product};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_acc   <= '0;
            r_ovf   <= 1'b0;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && io_bus.start) begin
                r_acc   <= '0;
                r_ovf   <= 1'b0;
                r_count <= '0;
            end else if (w_xfer) begin
                r_acc   <= w_sum[ACC_WIDTH-1:0];
                r_ovf   <= r_ovf | w_sum[ACC_WIDTH];
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_next           = r_state;
        io_bus.in_ready  = 1'b0;
        io_bus.out_valid = 1'b0;
        io_bus.busy      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (io_bus.start) begin
                    w_next = S_ACCUM;
                end
            end
            S_ACCUM: begin
                io_bus.in_ready = 1'b1;
                io_bus.busy     = 1'b1;
                if (w_xfer && w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                io_bus.out_valid = 1'b1;
                io_bus.busy      = 1'b1;
                if (io_bus.out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // acc keeps the last result through IDLE until the next start clears it.
    assign io_bus.acc = r_acc;
    assign io_bus.ovf = r_ovf;
endmodule

// File: tb/tb_wallace_product_accumulator.sv
module tb_wallace_product_accumulator;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    logic [15:0] a_prod [0:7];

    wallace_product_accumulator_if #(.ACC_WIDTH(19)) ia();
    wallace_product_accumulator_if #(.ACC_WIDTH(16)) ib();
    wallace_product_accumulator_if #(.ACC_WIDTH(19)) ic();

    wallace_product_accumulator #(.N_TERMS(8), .ACC_WIDTH(19)) u_a (
        .i_clk(clk), .i_rst(rst), .io_bus(ia.slave)
    );
    wallace_product_accumulator #(.N_TERMS(2), .ACC_WIDTH(16)) u_b (
        .i_clk(clk), .i_rst(rst), .io_bus(ib.slave)
    );
    wallace_product_accumulator #(.N_TERMS(1), .ACC_WIDTH(19)) u_c (
        .i_clk(clk), .i_rst(rst), .io_bus(ic.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: the result is the plain sum of the products modulo 2^W, and
    // the sticky carry is set exactly when that plain sum reaches 2^W.
    function automatic longint model_sum(input int n);
        longint s = 0;
        for (int i = 0; i < n; i++) s += a_prod[i];
        return s;
    endfunction

    // One 8-term operation on DUT A. vmode: 0 = in_valid always high,
    // 1 = toggled 1,0,1,0..., 2 = random gaps. Entered and left at a negedge.
    task automatic op_a(input int vmode, input int bp, input bit poke_start);
        longint sum;
        logic [31:0] exp_acc;
        logic [31:0] exp_ovf;
        int  idx;
        int  cyc;
        bit  v;
        sum     = model_sum(8);
        exp_acc = 32'(sum % (64'd1 << 19));
        exp_ovf = (sum >= (64'd1 << 19)) ? 32'd1 : 32'd0;
        ia.start = 1'b1; ia.in_valid = 1'b0;
        @(negedge clk);
        ia.start = 1'b0;
        check("a_busy_accum", 32'(ia.busy), 32'd1);
        idx = 0; cyc = 0;
        while (idx < 8 && cyc < 200) begin
            check("a_in_ready_accum", 32'(ia.in_ready), 32'd1);
            check("a_no_early_out_valid", 32'(ia.out_valid), 32'd0);
            case (vmode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = ($urandom_range(0, 3) != 0);
            endcase
            ia.in_valid = v;
            ia.product  = v ? a_prod[idx] : 16'($urandom);
            ia.start    = poke_start & 1'($urandom);
            @(posedge clk);
            if (v) idx++;
            cyc++;
            @(negedge clk);
        end
        ia.in_valid = 1'b0; ia.start = 1'b0;
        check("a_transfer_count", 32'(idx), 32'd8);
        if (vmode == 0) check("a_latency", 32'(cyc + 1), 32'd9);
        check("a_out_valid", 32'(ia.out_valid), 32'd1);
        check("a_in_ready_done", 32'(ia.in_ready), 32'd0);
        check("a_acc", 32'(ia.acc), exp_acc);
        check("a_ovf", 32'(ia.ovf), exp_ovf);
        for (int k = 0; k < bp; k++) begin
            ia.out_ready = 1'b0;
            ia.start     = poke_start;
            ia.in_valid  = 1'b1;
            @(negedge clk);
            check("a_bp_out_valid", 32'(ia.out_valid), 32'd1);
            check("a_bp_acc", 32'(ia.acc), exp_acc);
        end
        ia.start = 1'b0; ia.in_valid = 1'b0; ia.out_ready = 1'b1;
        @(negedge clk);
        ia.out_ready = 1'b0;
        check("a_release_out_valid", 32'(ia.out_valid), 32'd0);
        check("a_release_busy", 32'(ia.busy), 32'd0);
        check("a_idle_acc_held", 32'(ia.acc), exp_acc);
    endtask

    // Two-term operation on DUT B (16-bit accumulator), back-to-back products.
    task automatic op_b(input logic [15:0] p0, input logic [15:0] p1);
        longint sum;
        sum = longint'(p0) + longint'(p1);
        ib.start = 1'b1;
        @(negedge clk);
        ib.start = 1'b0; ib.in_valid = 1'b1; ib.product = p0;
        @(negedge clk);
        check("b_mid_out_valid", 32'(ib.out_valid), 32'd0);
        ib.product = p1;
        @(negedge clk);
        ib.in_valid = 1'b0;
        check("b_out_valid", 32'(ib.out_valid), 32'd1);
        check("b_acc", 32'(ib.acc), 32'(sum % 65536));
        check("b_ovf", 32'(ib.ovf), (sum >= 65536) ? 32'd1 : 32'd0);
        ib.out_ready = 1'b1;
        @(negedge clk);
        ib.out_ready = 1'b0;
        check("b_release", 32'(ib.out_valid), 32'd0);
    endtask

    // Single-term operation on DUT C; out_ready held high so the result is
    // visible for exactly one cycle.
    task automatic op_c(input logic [15:0] p);
        ic.start = 1'b1;
        @(negedge clk);
        ic.start = 1'b0; ic.in_valid = 1'b1; ic.product = p; ic.out_ready = 1'b1;
        @(negedge clk);
        ic.in_valid = 1'b0;
        check("c_out_valid", 32'(ic.out_valid), 32'd1);
        check("c_acc", 32'(ic.acc), 32'(p));
        check("c_ovf", 32'(ic.ovf), 32'd0);
        @(negedge clk);
        ic.out_ready = 1'b0;
        check("c_one_cycle", 32'(ic.out_valid), 32'd0);
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst = 1'b1;
        ia.start = 0; ia.in_valid = 0; ia.product = '0; ia.out_ready = 0;
        ib.start = 0; ib.in_valid = 0; ib.product = '0; ib.out_ready = 0;
        ic.start = 0; ic.in_valid = 0; ic.product = '0; ic.out_ready = 0;
        repeat (2) @(negedge clk);
        check("rst_a_acc", 32'(ia.acc), 32'd0);
        check("rst_a_ovf", 32'(ia.ovf), 32'd0);
        check("rst_a_busy", 32'(ia.busy), 32'd0);
        check("rst_a_in_ready", 32'(ia.in_ready), 32'd0);
        check("rst_a_out_valid", 32'(ia.out_valid), 32'd0);
        check("rst_b_out_valid", 32'(ib.out_valid), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: eight 255*255 products back-to-back
        for (int i = 0; i < 8; i++) a_prod[i] = 16'hFE01;
        op_a(0, 0, 1'b0);
        check("t1_acc_value", 32'(ia.acc), 32'h7F008);

        // 2: products 1..8 with in_valid toggling
        for (int i = 0; i < 8; i++) a_prod[i] = 16'(i + 1);
        op_a(1, 0, 1'b0);
        check("t2_acc_value", 32'(ia.acc), 32'd36);

        // 3: 16-bit accumulator wraps and sets ovf; next op clears it
        op_b(16'hFE01, 16'hFE01);
        op_b(16'd1, 16'd2);

        // 4: reset mid-operation
        ia.start = 1'b1;
        @(negedge clk);
        ia.start = 1'b0; ia.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ia.product = 16'($urandom);
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t4_busy", 32'(ia.busy), 32'd0);
        check("t4_acc", 32'(ia.acc), 32'd0);
        check("t4_in_ready", 32'(ia.in_ready), 32'd0);
        repeat (10) begin
            @(negedge clk);
            check("t4_no_result", 32'(ia.out_valid), 32'd0);
        end
        ia.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) a_prod[i] = 16'h0001;
        op_a(0, 0, 1'b0);
        check("t4_acc_value", 32'(ia.acc), 32'd8);

        // 5: back-pressure in DONE, start pokes in ACCUM/DONE
        for (int i = 0; i < 8; i++) a_prod[i] = 16'($urandom);
        op_a(2, 5, 1'b1);

        // 6: single-term configuration
        op_c(16'h1234);

        // randomized operations against the arithmetic model
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 8; i++) a_prod[i] = 16'($urandom);
            op_a(2, $urandom_range(0, 3), 1'b1);
            op_b(16'($urandom), 16'($urandom));
            op_c(16'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
